// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// LoadStoreUnit: connects a CPU byte/half/word request port to a word-wide
// data memory. The memory has a registered read, so every read takes two
// cycles. Byte and half stores are done as read-modify-write. Illegal or
// misaligned requests are rejected without touching the memory.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   req_write              : 1 = store, 0 = load
//   req_size               : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned           : zero-extend (1) or sign-extend (0) loads
//   req_addr, req_wdata    : byte address, right-aligned store data
//   resp_valid             : one-cycle completion pulse
//   resp_rdata, resp_err   : extended load data / rejection flag
//   MemRead, MemWrite      : data memory strobes
//   mem_addr, mem_wdata    : word index and write word
//   mem_rdata              : memory read word (one cycle after MemRead)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] RD2  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [2:0]       state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] word_q, word_d;

  logic             reqIllegal;
  logic [WIDTH-1:0] reqWordIndex;
  logic [4:0]       laneShift;
  logic [WIDTH-1:0] laneWord;
  logic [WIDTH-1:0] loadData;
  logic [WIDTH-1:0] laneMask;
  logic [WIDTH-1:0] mergeData;
  logic [WIDTH-1:0] storeData;
  logic             memActive;

  // Rejection is decided on the incoming request so that a bad request
  // never reaches a memory state.
  always_comb begin
    reqWordIndex = req_addr >> 2;
    reqIllegal   = 1'b0;
    if (req_size == SZ_ILL)                              reqIllegal = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])              reqIllegal = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)   reqIllegal = 1'b1;
    if (reqWordIndex >= WIDTH'(DEPTH))                   reqIllegal = 1'b1;
  end

  // Next-state and request capture. Fields are latched only on accept so
  // that req_* may change freely while a request is in flight.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    word_d     = word_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          err_d      = reqIllegal;
          if (reqIllegal)                              state_d = RESP;
          else if (req_write && req_size == SZ_WORD)   state_d = WR;
          else                                         state_d = RD1;
        end
      end
      RD1:  state_d = RD2;
      RD2: begin
        word_d  = mem_rdata;
        state_d = write_q ? WR : RESP;
      end
      WR:   state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      word_q     <= word_d;
    end
  end

  // Lane handling: shift the addressed lane down for loads, and build a
  // lane mask for merging store data into the captured word.
  always_comb begin
    laneShift = (size_q == SZ_HALF) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    laneWord  = word_q >> laneShift;
    case (size_q)
      SZ_BYTE: loadData = {{(WIDTH-8){~unsigned_q & laneWord[7]}}, laneWord[7:0]};
      SZ_HALF: loadData = {{(WIDTH-16){~unsigned_q & laneWord[15]}}, laneWord[15:0]};
      default: loadData = word_q;
    endcase
    laneMask  = ((size_q == SZ_HALF) ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF)) << laneShift;
    mergeData = (word_q & ~laneMask) | ((wdata_q << laneShift) & laneMask);
    storeData = (size_q == SZ_WORD) ? wdata_q : mergeData;
  end

  assign memActive  = (state_q == RD1) || (state_q == RD2) || (state_q == WR);
  assign req_ready  = (state_q == IDLE) && !rst;
  assign MemRead    = (state_q == RD1) || (state_q == RD2);
  assign MemWrite   = (state_q == WR);
  assign mem_addr   = memActive ? (addr_q >> 2) : '0;
  assign mem_wdata  = (state_q == WR) ? storeData : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP && !err_q && !write_q) ? loadData : '0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter DEPTH, default 512: number of words in the downstream data memory.
REQ-003 SHALL have clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have req_valid, input, 1: CPU access request.
REQ-006 SHALL have req_ready, output, 1: unit can accept a request.
REQ-007 SHALL have req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have req_size, input, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have req_unsigned, input, 1: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 SHALL have req_addr, input, WIDTH: byte address.
REQ-011 SHALL have req_wdata, input, WIDTH: store data, right-aligned.
REQ-012 SHALL have resp_valid, output, 1: one-cycle completion pulse.
REQ-013 SHALL have resp_rdata, output, WIDTH: extended load data; 0 for stores and errors.
REQ-014 SHALL have resp_err, output, 1: request rejected; valid only with resp_valid.
REQ-015 SHALL have MemRead, output, 1: read strobe to the data memory.
REQ-016 SHALL have MemWrite, output, 1: write strobe to the data memory.
REQ-017 SHALL have mem_addr, output, WIDTH: word index, equal to req_addr >> 2.
REQ-018 SHALL have mem_wdata, output, WIDTH: word written to the data memory.
REQ-019 SHALL have mem_rdata, input, WIDTH: data memory read data, valid one cycle after MemRead rises, and only while MemRead stays high.

Function
REQ-020 SHALL implement FSM states IDLE, RD1, RD2, WR, RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on an edge where req_valid && req_ready; accepting latches all request fields.
REQ-022 SHALL reject on accept (in IDLE) any of: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 0; word index >= DEPTH.
REQ-023 SHALL, for a rejected request, go to RESP with resp_err = 1 and resp_rdata = 0, asserting no MemRead or MemWrite.
REQ-024 SHALL sequence a load as IDLE -> RD1 -> RD2 -> RESP -> IDLE.
REQ-025 SHALL hold MemRead high throughout RD1 and RD2, and register mem_rdata at the end of RD2.
REQ-026 SHALL sequence a word store as IDLE -> WR -> RESP -> IDLE, with MemWrite = 1 and mem_wdata = req_wdata in WR.
REQ-027 SHALL sequence a byte or half store as read-modify-write: IDLE -> RD1 -> RD2 -> WR -> RESP -> IDLE.
REQ-028 SHALL, in WR of a read-modify-write, write the captured word with only the addressed lanes replaced by low bits of req_wdata.
REQ-029 SHALL use little-endian lanes: byte lane = addr[1:0], bits 8*lane+7 : 8*lane; half lane = addr[1], bits 16*addr[1]+15 : 16*addr[1].
REQ-030 SHALL extend loads by req_unsigned: byte/half zero-extended if 1, sign-extended from lane MSB if 0; word loads pass unchanged.
REQ-031 SHALL never assert MemRead and MemWrite in the same cycle; MemRead = 0 in WR.
REQ-032 SHALL hold mem_addr constant from RD1 through WR of one request; mem_addr and mem_wdata = 0 in IDLE and RESP.
REQ-033 SHALL assert resp_valid only in RESP, for exactly one cycle, without backpressure.
REQ-034 SHALL complete with latency from the accept edge: word store 2 cycles, load 3, sub-word store 4, error 1.
REQ-035 SHALL ignore req_valid outside IDLE; no request is queued.

Reset
REQ-036 SHALL, while rst = 1, force state IDLE and all outputs 0 except req_ready, which SHALL be 1 once rst is released.
REQ-037 SHALL abandon any in-flight access on rst; if rst asserts before the WR edge, the memory is not written and no resp_valid is produced.

Verification
REQ-038 SHALL pass: word store 0xDEADBEEF at 0x10 -> MemWrite with mem_addr 4 and mem_wdata 0xDEADBEEF in the cycle after accept; resp_valid 2 cycles after accept.
REQ-039 SHALL pass: then byte store 0xAA at 0x13 -> MemRead for 2 cycles at addr 4, then MemWrite with 0xAAADBEEF; resp_valid 4 cycles after accept.
REQ-040 SHALL pass: byte load at 0x13 -> 0xFFFFFFAA when signed, 0x000000AA when unsigned; half load at 0x12, signed -> 0xFFFFAAAD; resp_valid 3 cycles after accept.
REQ-041 SHALL pass: half load at 0x11, size 11, and byte load at 0x800 -> each gives resp_err = 1 one cycle after accept, with no MemRead or MemWrite.
REQ-042 SHALL pass: rst pulse during RD2 of a sub-word store -> outputs 0 immediately, no MemWrite, word 4 unchanged, req_ready = 1 after release.
REQ-043 SHALL pass: req_valid held high across back-to-back requests -> each accepted only in IDLE, and responses stay in request order.
